// File: rtl/sifh_hist_readout_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sifh_hist_readout_pkg
// Purpose  : Shared widths, FSM states and beat record for the histogram reader.
// Revision : 1.0
// ============================================================================
package sifh_hist_readout_pkg;

  localparam int NB        = 10;
  localparam int PEAK_MAX  = 16;
  localparam int PIXEL_NUM = 4;

  function automatic int pw_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int PW = pw_of(PIXEL_NUM);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [PW-1:0]       pixel;
    logic [NB-1:0]       bin;
    logic [PEAK_MAX-1:0] count;
    logic                last;
  } beat_t;

endpackage
`default_nettype wire

// File: rtl/sifh_rd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sifh_rd_fifo
// Purpose  : Two-entry synchronous FIFO of readout beats with occupancy output.
// Revision : 1.0
// ============================================================================
module sifh_rd_fifo
  import sifh_hist_readout_pkg::*;
#(
  parameter type T = beat_t
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  T           i_data,
  input  logic       i_pop,
  output T           o_head,
  output logic [1:0] o_count
);

  T           r_mem [2];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_count;
  logic       w_push;
  logic       w_pop;

  assign w_pop  = i_pop && (r_count != 2'd0);
  assign w_push = i_push && ((r_count != 2'd2) || w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + 2'(w_push) - 2'(w_pop);
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/sifh_hist_readout.sv
`default_nettype none
// ============================================================================
// Module   : sifh_hist_readout
// Purpose  : Scans every {pixel, bin} of the histogram RAM and streams beats;
//            SIFH_RD_CLEAR_EN enables clearing each bin as it is read.
// Revision : 1.0
// ============================================================================
module sifh_hist_readout #(
  parameter  int NB        = sifh_hist_readout_pkg::NB,
  parameter  int PEAK_MAX  = sifh_hist_readout_pkg::PEAK_MAX,
  parameter  int PIXEL_NUM = sifh_hist_readout_pkg::PIXEL_NUM,
  localparam int PW        = sifh_hist_readout_pkg::pw_of(PIXEL_NUM)
) (
  input  logic                clk,
  input  logic                res,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [PW+NB-1:0]    raddr,
  output logic                rEnable,
  output logic                readFlag,
  input  logic [PEAK_MAX-1:0] rdata,
  output logic [PW+NB-1:0]    waddr,
  output logic [PEAK_MAX-1:0] wdata,
  output logic                wEnable,
  output logic                writeFlag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PW-1:0]       out_pixel,
  output logic [NB-1:0]       out_bin,
  output logic [PEAK_MAX-1:0] out_count,
  output logic                out_last
);
  import sifh_hist_readout_pkg::*;

  typedef struct packed {
    logic [PW-1:0]       pixel;
    logic [NB-1:0]       bin;
    logic [PEAK_MAX-1:0] count;
    logic                last;
  } rd_beat_t;

  localparam logic [PW-1:0] c_PIX_LAST = PW'(PIXEL_NUM - 1);
  localparam logic [NB-1:0] c_BIN_LAST = '1;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [PW-1:0]     r_pix;
  logic [NB-1:0]     r_bin;
  logic              r_inflight;
  logic [PW+NB-1:0]  r_inflight_addr;
  logic              r_inflight_last;
  rd_beat_t          w_push_beat;
  rd_beat_t          w_head;
  logic [1:0]        w_fifo_count;
  logic              w_out_valid;
  logic              w_pop;
  logic              w_issue;
  logic              w_scan_last;

  assign w_out_valid = (w_fifo_count != 2'd0);
  assign w_pop       = w_out_valid && out_ready;
  assign w_scan_last = (r_pix == c_PIX_LAST) && (r_bin == c_BIN_LAST);

  // Counting the beat leaving this cycle as free space keeps one read per
  // cycle under full throughput while never overfilling the two entries.
  assign w_issue = (r_state == ST_READ) &&
                   (({1'b0, w_fifo_count} - 3'(w_pop) + 3'(r_inflight)) < 3'd2);

  always_ff @(posedge clk) begin
    if (res) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_state_nxt = ST_READ;
      ST_READ:  if (w_issue && w_scan_last) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if ((w_fifo_count == 2'd0) && !r_inflight) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    readFlag = 1'b0;
    rEnable  = 1'b1;
    case (r_state)
      ST_READ: begin
        busy     = 1'b1;
        readFlag = w_issue;
        rEnable  = ~w_issue;
      end
      ST_DRAIN: busy = 1'b1;
      ST_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      r_pix           <= '0;
      r_bin           <= '0;
      r_inflight      <= 1'b0;
      r_inflight_addr <= '0;
      r_inflight_last <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_addr <= {r_pix, r_bin};
        r_inflight_last <= w_scan_last;
        // Explicit return to zero so non-power-of-two pixel counts never overrun.
        if (w_scan_last) begin
          r_pix <= '0;
          r_bin <= '0;
        end else if (r_bin == c_BIN_LAST) begin
          r_bin <= '0;
          r_pix <= r_pix + PW'(1);
        end else begin
          r_bin <= r_bin + NB'(1);
        end
      end
    end
  end

  assign w_push_beat = '{pixel: r_inflight_addr[PW+NB-1:NB],
                         bin:   r_inflight_addr[NB-1:0],
                         count: rdata,
                         last:  r_inflight_last};

  sifh_rd_fifo #(
    .T (rd_beat_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (res),
    .i_push  (r_inflight),
    .i_data  (w_push_beat),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_fifo_count)
  );

  assign raddr     = {r_pix, r_bin};
  assign wdata     = '0;
  assign out_valid = w_out_valid;
  assign out_pixel = w_out_valid ? w_head.pixel : '0;
  assign out_bin   = w_out_valid ? w_head.bin   : '0;
  assign out_count = w_out_valid ? w_head.count : '0;
  assign out_last  = w_out_valid ? w_head.last  : 1'b0;

`ifdef SIFH_RD_CLEAR_EN
  assign writeFlag = r_inflight;
  assign wEnable   = r_inflight;
  assign waddr     = r_inflight ? r_inflight_addr : '0;
`else
  assign writeFlag = 1'b0;
  assign wEnable   = 1'b0;
  assign waddr     = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sifh_hist_readout.sv
`default_nettype none
// ============================================================================
// Module   : tb_sifh_hist_readout
// Purpose  : Scoreboard bench for sifh_hist_readout with a behavioural RAM;
//            expectations follow SIFH_RD_CLEAR_EN when it is defined.
// Revision : 1.0
// ============================================================================
module tb_sifh_hist_readout;

  localparam int NB        = 3;
  localparam int PEAK_MAX  = 16;
  localparam int PIXEL_NUM = 2;
  localparam int PW        = 1;
  localparam int AW        = PW + NB;
  localparam int NBEAT     = PIXEL_NUM * (1 << NB);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                res, start, out_ready, preload;
  logic                busy, done, rEnable, readFlag, wEnable, writeFlag;
  logic                out_valid, out_last;
  logic [AW-1:0]       raddr, waddr;
  logic [PEAK_MAX-1:0] rdata, wdata, out_count;
  logic [PW-1:0]       out_pixel;
  logic [NB-1:0]       out_bin;

  sifh_hist_readout #(
    .NB        (NB),
    .PEAK_MAX  (PEAK_MAX),
    .PIXEL_NUM (PIXEL_NUM)
  ) dut (
    .clk       (clk),
    .res       (res),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .raddr     (raddr),
    .rEnable   (rEnable),
    .readFlag  (readFlag),
    .rdata     (rdata),
    .waddr     (waddr),
    .wdata     (wdata),
    .wEnable   (wEnable),
    .writeFlag (writeFlag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pixel (out_pixel),
    .out_bin   (out_bin),
    .out_count (out_count),
    .out_last  (out_last)
  );

  // Dual-port RAM: port b reads with one cycle latency, port a writes.
  logic [PEAK_MAX-1:0] ram [NBEAT];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < NBEAT; i++) ram[i] <= PEAK_MAX'(i + 1);
    end else begin
      if (readFlag && !rEnable) rdata <= ram[raddr];
      if (writeFlag && wEnable) ram[waddr] <= wdata;
    end
  end

  typedef struct packed {
    logic [PW-1:0]       pix;
    logic [NB-1:0]       bin;
    logic [PEAK_MAX-1:0] cnt;
    logic                last;
  } beat_t;

  typedef struct {
    bit do_preload;
    bit rnd_ready;
    bit mid_start;
    int exp_done;
  } scan_vec_t;

  beat_t               exp_q[$];
  logic [PEAK_MAX-1:0] exp_mem [NBEAT];
  int checks = 0;
  int errors = 0;
  int beats_seen = 0;
  int wr_seen = 0;
  logic mon_en = 1'b0;
  logic held = 1'b0;
  beat_t held_beat;
  beat_t act;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      act = {out_pixel, out_bin, out_count, out_last};
      if (writeFlag) wr_seen++;
      if (held) begin
        chk("valid_held", 64'(out_valid), 64'd1);
        chk("beat_stable", 64'(act), 64'(held_beat));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_beat: got %0h expected none", act);
        end else begin
          chk("beat", 64'(act), 64'(exp_q.pop_front()));
        end
        beats_seen++;
        held = 1'b0;
      end else begin
        held      = out_valid;
        held_beat = act;
      end
    end else begin
      held = 1'b0;
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ctrl"}, 64'({out_valid, busy, done, readFlag, rEnable, writeFlag, wEnable}),
        64'(7'b0000100));
    chk({tag, "_addr"}, 64'({raddr, waddr}), 64'd0);
    chk({tag, "_data"}, 64'({out_pixel, out_bin, out_count, out_last}), 64'd0);
  endtask

  task automatic do_preload();
    @(posedge clk);
    #1 preload = 1'b1;
    @(posedge clk);
    #1 preload = 1'b0;
    for (int i = 0; i < NBEAT; i++) exp_mem[i] = PEAK_MAX'(i + 1);
  endtask

  task automatic push_expected();
    for (int i = 0; i < NBEAT; i++)
      exp_q.push_back(beat_t'({PW'(i >> NB), NB'(i), exp_mem[i], 1'(i == NBEAT - 1)}));
  endtask

  task automatic run_scan(input bit rnd, input bit mid, input int exp_done, input string tag);
    int done_cyc;
    int done_cnt;
    done_cyc = -1;
    done_cnt = 0;
    push_expected();
    beats_seen = 0;
    wr_seen    = 0;
    @(posedge clk);
    #1 start = 1'b1;
    out_ready = 1'b1;
    for (int n = 1; n < 400; n++) begin
      @(posedge clk);
      #1 start = mid && (n == 8);
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (n == 1) chk({tag, "_busy"}, 64'(busy), 64'd1);
      if (!rnd && (n == 2 || n == 3)) chk({tag, "_valid_rise"}, 64'(out_valid), 64'(n == 3));
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = n;
      end
      if (done_cyc >= 0 && n >= done_cyc + 3) break;
    end
    chk({tag, "_done_seen"}, 64'(done_cyc >= 0), 64'd1);
    if (exp_done > 0) chk({tag, "_done_cycle"}, 64'(done_cyc), 64'(exp_done));
    chk({tag, "_done_count"}, 64'(done_cnt), 64'd1);
    chk({tag, "_beats"}, 64'(beats_seen), 64'(NBEAT));
    chk({tag, "_queue_left"}, 64'(exp_q.size()), 64'd0);
    chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
`ifdef SIFH_RD_CLEAR_EN
    chk({tag, "_writes"}, 64'(wr_seen), 64'(NBEAT));
    for (int i = 0; i < NBEAT; i++) exp_mem[i] = '0;
`else
    chk({tag, "_writes"}, 64'(wr_seen), 64'd0);
`endif
    for (int i = 0; i < NBEAT; i++) chk({tag, "_ram"}, 64'(ram[i]), 64'(exp_mem[i]));
    exp_q.delete();
  endtask

  scan_vec_t vecs [4];

  initial begin
    int n;
    vecs[0] = '{do_preload: 1'b1, rnd_ready: 1'b0, mid_start: 1'b0, exp_done: 20};
    vecs[1] = '{do_preload: 1'b0, rnd_ready: 1'b0, mid_start: 1'b0, exp_done: 20};
    vecs[2] = '{do_preload: 1'b1, rnd_ready: 1'b1, mid_start: 1'b0, exp_done: 0};
    vecs[3] = '{do_preload: 1'b1, rnd_ready: 1'b0, mid_start: 1'b1, exp_done: 20};

    res = 1'b1;
    start = 1'b0;
    out_ready = 1'b0;
    preload = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("por");
    @(posedge clk);
    #1 res = 1'b0;
    mon_en = 1'b1;

    for (int v = 0; v < 4; v++) begin
      if (vecs[v].do_preload) do_preload();
      run_scan(vecs[v].rnd_ready, vecs[v].mid_start, vecs[v].exp_done, $sformatf("scan%0d", v));
    end

    // Reset after the fifth beat, then a clean rescan from address zero.
    do_preload();
    push_expected();
    beats_seen = 0;
    @(posedge clk);
    #1 start = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    while (beats_seen < 5 && n < 100) begin
      @(negedge clk);
      #1 n++;
    end
    chk("midres_beats", 64'(beats_seen), 64'd5);
    @(posedge clk);
    #1 res = 1'b1;
    out_ready = 1'b0;
    mon_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midres");
    @(posedge clk);
    #1 res = 1'b0;
    exp_q.delete();
    mon_en = 1'b1;
    do_preload();
    run_scan(1'b0, 1'b0, 20, "rescan");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
